rev_cnt_sched: RTL and testbench

REV_CNT_SCHED -- requirements
Module: rev_cnt_sched

---
 rtl/rev_cnt_sched_if.sv | 36 +++
 rtl/rev_cnt_sched.sv | 121 ++++++++++++
 tb/tb_rev_cnt_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rev_cnt_sched_if.sv
// rtl/rev_cnt_sched_if.sv - command/status bundle for the reversible counter scheduler
// The abort line exists only when REV_CNT_SCHED_ABORT_EN is defined.
interface rev_cnt_sched_if;
    logic       req;
    logic       dir;
    logic [3:0] steps;
    logic       sweep;
    logic [3:0] lo;
    logic [3:0] hi;
`ifdef REV_CNT_SCHED_ABORT_EN
    logic       abort;
`endif
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       S;
    logic [3:0] cnt;
    logic       Rc;

    modport master (
`ifdef REV_CNT_SCHED_ABORT_EN
        output abort,
`endif
        output req, dir, steps, sweep, lo, hi,
        input  ack, busy, done, err, S, cnt, Rc
    );

    modport slave (
`ifdef REV_CNT_SCHED_ABORT_EN
        input  abort,
`endif
        input  req, dir, steps, sweep, lo, hi,
        output ack, busy, done, err, S, cnt, Rc
    );
endinterface

// File: rtl/rev_cnt_sched.sv
// rtl/rev_cnt_sched.sv - reversible 4-bit counter with single-run and bounded sweep commands
// Optional abort input enabled by defining REV_CNT_SCHED_ABORT_EN.
module rev_cnt_sched #(
    parameter int SWEEP_TURNS = 2
) (
    input  logic           clk,
    input  logic           rst,
    rev_cnt_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, SWEEP, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt_q, cnt_nx;
    logic [3:0] lo_q, lo_nx;
    logic [3:0] hi_q, hi_nx;
    logic [3:0] turn_q, turn_nx;
    logic [4:0] rem_q, rem_nx;
    logic       s_q, s_nx;
    logic       ack_q, ack_nx;
    logic       err_q, err_nx;
    logic       abort_hit;
    logic [3:0] step_val;
    logic [3:0] bound;

`ifdef REV_CNT_SCHED_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign step_val = s_q ? cnt_q + 4'd1 : cnt_q - 4'd1;
    assign bound    = s_q ? hi_q : lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 4'd0;
            lo_q   <= 4'd0;
            hi_q   <= 4'd0;
            turn_q <= 4'd0;
            rem_q  <= 5'd0;
            s_q    <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_nx;
            lo_q   <= lo_nx;
            hi_q   <= hi_nx;
            turn_q <= turn_nx;
            rem_q  <= rem_nx;
            s_q    <= s_nx;
            ack_q  <= ack_nx;
            err_q  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        lo_nx    = lo_q;
        hi_nx    = hi_q;
        turn_nx  = turn_q;
        rem_nx   = rem_q;
        s_nx     = s_q;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    lo_nx    = bus.lo;
                    hi_nx    = bus.hi;
                    s_nx     = bus.dir;
                    rem_nx   = (bus.steps == 4'd0) ? 5'd16 : {1'b0, bus.steps};
                    turn_nx  = 4'd0;
                    ack_nx   = 1'b1;
                    state_nx = bus.sweep ? SWEEP : RUN;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = step_val;
                    rem_nx = rem_q - 5'd1;
                    if (rem_q == 5'd1) state_nx = DONE;
                end
            end
            SWEEP: begin
                if (abort_hit || (lo_q > hi_q)) begin
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else if (cnt_q != bound) begin
                    cnt_nx = step_val;
                end else begin
                    // dwell: reverse without moving, count the turn
                    s_nx    = ~s_q;
                    turn_nx = turn_q + 4'd1;
                    if (turn_q + 4'd1 == 4'(SWEEP_TURNS)) state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ack  = ack_q;
    assign bus.busy = (state == RUN) || (state == SWEEP);
    assign bus.done = (state == DONE);
    assign bus.err  = err_q;
    assign bus.S    = s_q;
    assign bus.cnt  = cnt_q;
    assign bus.Rc   = (s_q && (cnt_q == 4'd15)) || (!s_q && (cnt_q == 4'd0));
endmodule

// File: tb/tb_rev_cnt_sched.sv
// tb/tb_rev_cnt_sched.sv - directed self-checking bench for rev_cnt_sched
module tb_rev_cnt_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    rev_cnt_sched_if bus();

    rev_cnt_sched #(.SWEEP_TURNS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_n(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cmd(input logic d, input logic [3:0] n, input logic sw,
                       input logic [3:0] l, input logic [3:0] h);
        bus.req = 1'b1; bus.dir = d; bus.steps = n; bus.sweep = sw; bus.lo = l; bus.hi = h;
        tick();
        bus.req = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0; bus.dir = 1'b0; bus.steps = 4'd0; bus.sweep = 1'b0;
        bus.lo = 4'd0; bus.hi = 4'd0;
`ifdef REV_CNT_SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif
        #3;
        chk_n("rst_cnt", bus.cnt, 4'd0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_done", bus.done, 1'b0);
        chk_b("rst_ack", bus.ack, 1'b0);
        chk_b("rst_S", bus.S, 1'b0);
        chk_b("rst_Rc", bus.Rc, 1'b1);
        tick(); tick();
        rst = 1'b1;

        // single up run of 3, with a stray req while running
        cmd(1'b1, 4'd3, 1'b0, 4'd0, 4'd0);
        chk_b("up_ack", bus.ack, 1'b1);
        chk_b("up_busy", bus.busy, 1'b1);
        chk_n("up_cnt0", bus.cnt, 4'd0);
        chk_b("up_S", bus.S, 1'b1);
        tick();
        chk_n("up_cnt1", bus.cnt, 4'd1);
        chk_b("up_ack_gone", bus.ack, 1'b0);
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk_b("stray_no_ack", bus.ack, 1'b0);
        chk_n("up_cnt2", bus.cnt, 4'd2);
        tick();
        chk_n("up_cnt3", bus.cnt, 4'd3);
        chk_b("up_done", bus.done, 1'b1);
        chk_b("up_err", bus.err, 1'b0);
        chk_b("up_busy_done", bus.busy, 1'b0);
        tick();
        chk_b("up_done_clr", bus.done, 1'b0);
        chk_n("up_hold", bus.cnt, 4'd3);
        tick();
        chk_b("stray_ignored", bus.busy, 1'b0);

        // down 2 to reach cnt=1
        cmd(1'b0, 4'd2, 1'b0, 4'd0, 4'd0);
        tick(); tick(); tick();
        chk_n("pre16_cnt", bus.cnt, 4'd1);

        // steps=0 means 16 down steps, passing through 0
        cmd(1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        tick();
        chk_n("d16_cnt0", bus.cnt, 4'd0);
        chk_b("d16_Rc", bus.Rc, 1'b1);
        chk_b("d16_busy", bus.busy, 1'b1);
        chk_b("d16_nodone", bus.done, 1'b0);
        repeat (15) tick();
        chk_n("d16_end", bus.cnt, 4'd1);
        chk_b("d16_done", bus.done, 1'b1);
        tick();

        // down 1 to cnt=0, then sweep 2..5
        cmd(1'b0, 4'd1, 1'b0, 4'd0, 4'd0);
        tick(); tick();
        chk_n("pre_sw_cnt", bus.cnt, 4'd0);
        cmd(1'b1, 4'd0, 1'b1, 4'd2, 4'd5);
        chk_b("sw_ack", bus.ack, 1'b1);
        repeat (5) tick();
        chk_n("sw_top", bus.cnt, 4'd5);
        chk_b("sw_top_S", bus.S, 1'b1);
        tick();
        chk_n("sw_dwell_cnt", bus.cnt, 4'd5);
        chk_b("sw_dwell_S", bus.S, 1'b0);
        chk_b("sw_dwell_busy", bus.busy, 1'b1);
        repeat (3) tick();
        chk_n("sw_bot", bus.cnt, 4'd2);
        chk_b("sw_bot_nodone", bus.done, 1'b0);
        tick();
        chk_b("sw_done", bus.done, 1'b1);
        chk_b("sw_err", bus.err, 1'b0);
        chk_n("sw_end_cnt", bus.cnt, 4'd2);
        chk_b("sw_end_S", bus.S, 1'b1);
        tick();

        // inverted bounds: immediate error completion
        cmd(1'b1, 4'd0, 1'b1, 4'd9, 4'd3);
        chk_b("inv_ack", bus.ack, 1'b1);
        chk_b("inv_nodone", bus.done, 1'b0);
        tick();
        chk_b("inv_done", bus.done, 1'b1);
        chk_b("inv_err", bus.err, 1'b1);
        chk_n("inv_cnt", bus.cnt, 4'd2);
        tick();
        chk_b("inv_err_clr", bus.err, 1'b0);

        // start below window going down: wraps 2->0->15..8, then up to 10
        cmd(1'b0, 4'd0, 1'b1, 4'd8, 4'd10);
        repeat (10) tick();
        chk_n("wrap_lo", bus.cnt, 4'd8);
        chk_b("wrap_lo_S", bus.S, 1'b0);
        tick();
        chk_b("wrap_dwell_S", bus.S, 1'b1);
        repeat (2) tick();
        chk_n("wrap_hi", bus.cnt, 4'd10);
        tick();
        chk_b("wrap_done", bus.done, 1'b1);
        chk_b("wrap_end_S", bus.S, 1'b0);
        tick();

        // asynchronous reset mid-run
        cmd(1'b1, 4'd5, 1'b0, 4'd0, 4'd0);
        tick();
        chk_n("ar_cnt", bus.cnt, 4'd11);
        #2 rst = 1'b0;
        #1;
        chk_n("ar_cnt0", bus.cnt, 4'd0);
        chk_b("ar_busy", bus.busy, 1'b0);
        tick();
        chk_b("ar_nodone", bus.done, 1'b0);
        rst = 1'b1;
        cmd(1'b1, 4'd2, 1'b0, 4'd0, 4'd0);
        chk_b("ar_reaccept", bus.ack, 1'b1);
        tick(); tick();
        chk_b("ar_re_done", bus.done, 1'b1);
        chk_n("ar_re_cnt", bus.cnt, 4'd2);
        tick();

`ifdef REV_CNT_SCHED_ABORT_EN
        // abort in IDLE is ignored, abort at cnt=4 freezes
        bus.abort = 1'b1;
        tick();
        chk_b("ab_idle_nodone", bus.done, 1'b0);
        bus.abort = 1'b0;
        cmd(1'b1, 4'd8, 1'b0, 4'd0, 4'd0);
        tick(); tick();
        chk_n("ab_cnt4", bus.cnt, 4'd4);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_b("ab_done", bus.done, 1'b1);
        chk_b("ab_err", bus.err, 1'b1);
        chk_n("ab_cnt", bus.cnt, 4'd4);
        tick();
        chk_n("ab_hold", bus.cnt, 4'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
